// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared state encoding and timing constants for nonrestoring_divider.
// Revision : 1.0
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH      = 8;
    localparam int CYCLES_PER_BIT = 3;    // SHIFT, ADDSUB, TEST per quotient bit
    localparam int DIV_OVERHEAD   = 2;    // CORRECT and OUTPUT

    typedef logic [2:0] div_state_t;

    localparam div_state_t IDLE    = 3'd0;
    localparam div_state_t SHIFT   = 3'd1;
    localparam div_state_t ADDSUB  = 3'd2;
    localparam div_state_t TEST    = 3'd3;
    localparam div_state_t CORRECT = 3'd4;
    localparam div_state_t OUTPUT  = 3'd5;
    localparam div_state_t DIVZ    = 3'd6;

    // Cycles from the start-sampling edge through the done cycle, inclusive.
    function automatic int div_latency(input int width);
        return CYCLES_PER_BIT * width + DIV_OVERHEAD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_addsub.sv
`default_nettype none
// ============================================================================
// Module   : div_addsub
// Brief    : WIDTH+2-bit adder/subtractor shared by ADDSUB and CORRECT steps.
// Revision : 1.0
// ============================================================================
module div_addsub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH+1:0] a,
    input  logic [WIDTH+1:0] m,
    input  logic             sub,
    output logic [WIDTH+1:0] sum
);

    assign sum = sub ? (a - m) : (a + m);

endmodule
`default_nettype wire

// File: rtl/nonrestoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : nonrestoring_divider
// Brief    : Sequential radix-2 non-restoring unsigned divider, start/done handshake.
// Revision : 1.0
// ============================================================================
module nonrestoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int            c_AW       = WIDTH + 2;
    localparam int            c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH);

    div_state_t       r_state;
    logic [c_AW-1:0]  r_a;
    logic [c_AW-1:0]  r_m;
    logic [WIDTH-1:0] r_q;
    logic [c_CW-1:0]  r_cnt;
    logic             r_s;

    logic             w_sub;
    logic [c_AW-1:0]  w_sum;
    logic [c_AW-1:0]  w_a_corr;

    // Outside ADDSUB the shared adder only ever restores (A+M) in CORRECT.
    assign w_sub = (r_state == ADDSUB) ? ~r_s : 1'b0;

    div_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a   (r_a),
        .m   (r_m),
        .sub (w_sub),
        .sum (w_sum)
    );

    assign w_a_corr = r_a[c_AW-1] ? w_sum : r_a;

    assign busy = (r_state != IDLE);
    assign done = (r_state == OUTPUT) || (r_state == DIVZ);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_m         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_s         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_q   <= dividend;
                        r_m   <= {2'b00, divisor};
                        r_a   <= '0;
                        r_cnt <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            r_state     <= DIVZ;
                        end else begin
                            r_state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_s        <= r_a[c_AW-1];
                    {r_a, r_q} <= {r_a[c_AW-2:0], r_q, 1'b0};
                    r_state    <= ADDSUB;
                end
                ADDSUB: begin
                    r_a     <= w_sum;
                    r_q[0]  <= ~w_sum[c_AW-1];
                    r_cnt   <= r_cnt + c_CW'(1);
                    r_state <= TEST;
                end
                TEST: begin
                    r_state <= (r_cnt == c_CNT_LAST) ? CORRECT : SHIFT;
                end
                CORRECT: begin
                    r_a         <= w_a_corr;
                    quotient    <= r_q;
                    remainder   <= w_a_corr[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    r_state     <= OUTPUT;
                end
                OUTPUT: begin
                    r_state <= IDLE;
                end
                DIVZ: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/nonrestoring_divider.md
Name: nonrestoring_divider

Overview:
Sequential radix-2 non-restoring unsigned divider, the inverse operation to the team's Booth multiplier. It uses the same start/iterate/output control style.
- Takes dividend and divisor and iterates one quotient bit per 3-cycle SCAN-like loop.
- Produces quotient and remainder with a one-cycle done strobe.
- Sits beside the multiplier in the arithmetic unit; shares its start/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits (dividend, divisor, quotient, remainder)

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend, sampled with start
divisor  input  WIDTH  unsigned divisor, sampled with start
quotient  output  WIDTH  registered result, held until next result
remainder  output  WIDTH  registered result, held until next result
busy  output  1  high in every state except IDLE
done  output  1  one-cycle strobe, result valid
div_by_zero  output  1  valid with done; 1 when divisor was 0

Behaviour:
- Reset (async, rst_b=0):
  - state=IDLE.
  - A, Q, M, cnt, sign flag, quotient, remainder all 0.
  - busy=0, done=0, div_by_zero=0.
- Internal registers:
  - A: WIDTH+2 bits, two's complement partial remainder.
  - Q: WIDTH bits.
  - M: WIDTH+2 bits, zero-extended divisor.
  - cnt: clog2(WIDTH+1) bits.
  - s: sign flag, 1 bit.
- States: IDLE, SHIFT, ADDSUB, TEST, CORRECT, OUTPUT, DIVZ.
- IDLE:
  - On start=1: Q<=dividend, M<=divisor, A<=0, cnt<=0.
  - Next state is DIVZ if divisor==0, else SHIFT.
  - On start=0: stay in IDLE.
- SHIFT:
  - s<=A[msb] (sign before the shift).
  - {A,Q}<={A,Q}<<1; Q[0]<=0.
  - Next state: ADDSUB.
- ADDSUB:
  - Anew = s ? A+M : A-M.
  - A<=Anew; Q[0]<=~Anew[msb]; cnt<=cnt+1.
  - Next state: TEST.
- TEST:
  - cnt==WIDTH: go to CORRECT.
  - Otherwise: go to SHIFT.
- CORRECT:
  - If A[msb]=1, A<=A+M.
  - Also load quotient<=Q and remainder<=(corrected A)[WIDTH-1:0].
  - div_by_zero<=0.
  - Next state: OUTPUT.
- OUTPUT:
  - done=1 (decoded from state); next state IDLE.
- DIVZ:
  - quotient<=all ones, remainder<=dividend (latched Q), div_by_zero<=1.
  - done=1 during the DIVZ cycle itself; outputs are loaded on the IDLE->DIVZ edge.
  - Next state: IDLE.
- Latency:
  - start sampled at edge E0; done high in the cycle after edge E0+3*WIDTH+1.
  - Normal division: 3*WIDTH+2 cycles (26 for WIDTH=8).
  - Divide by zero: done high in the cycle right after E0.
- Arithmetic: all add/sub on WIDTH+2 bits and no overflow is possible. Invariant: -M <= A < M after every ADDSUB.
- Boundary conditions:
  - start while busy=1: ignored; operands not resampled.
  - start held high continuously: a new operation begins on the edge after OUTPUT/DIVZ returns to IDLE. Minimum issue interval is 3*WIDTH+3 cycles.
  - dividend < divisor: quotient=0, remainder=dividend.
  - dividend=0: quotient=0, remainder=0 (divisor≠0).
  - Reset mid-operation: immediate return to IDLE; quotient/remainder cleared to 0; no done pulse.
  - Outputs are never modified outside the CORRECT and DIVZ loads.

Decomposition:
- Shared package div_pkg: state encoding localparams (IDLE..DIVZ, 3-bit) and the default WIDTH.
- The same package holds the iteration-count constant, so the testbench can compute expected latency.
- One natural sub-module, div_addsub: WIDTH+2-bit combinational adder/subtractor with inputs a, m, sub and output sum. It is reused by ADDSUB and CORRECT.
- Controller and datapath stay in nonrestoring_divider.

Test Plan:
1. dividend=100, divisor=7, start for 1 cycle -> busy high 26 cycles; done high exactly 1 cycle at cycle 26; quotient=14, remainder=2, div_by_zero=0.
2. 255/1 then 5/9 back-to-back (start held) -> first result quotient=255 remainder=0; second quotient=0 remainder=5. Each done is 1 cycle; the second done comes 27 cycles after the first.
3. dividend=200, divisor=0 -> done in the cycle after start sampled; quotient=255, remainder=200, div_by_zero=1. The next valid division clears div_by_zero.
4. Start 100/7; pulse start with 50/5 at cycle 10 -> second request ignored; result still 14 r 2 at cycle 26.
5. Start 200/3; drop rst_b at cycle 12 -> busy=0, quotient=0, remainder=0 asynchronously; no done. After release, 200/3 -> 66 r 2.
6. Exhaustive sweep of all 256x255 nonzero-divisor pairs -> quotient/remainder match the reference model. done width is always 1 cycle and latency is always 26.
